// File: rtl/pgb_frame_capture_pkg.sv
// Shared definitions for the pGB frame capture sink: stream FSM encoding,
// default geometry and the pixels-per-word derivation.
package pgb_frame_capture_pkg;

    localparam int DEF_ADDR_W     = 13;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_PIX_W      = 2;
    localparam int DEF_LAST_ADDR  = 8191;
    localparam int DEF_LINE_WORDS = 32;
    localparam int DEF_NUM_BANKS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } streamState_t;

    function automatic int pixPerWord(input int dataW, input int pixW);
        return dataW / pixW;
    endfunction

endpackage

// File: rtl/pgb_fb_bank_ram.sv
// One framebuffer bank: simple dual-port RAM, one write port and one
// registered read port (data valid the cycle after iRe).
module pgb_fb_bank_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              iClock,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iRe,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge iClock) begin
        if (iWe) mem[iWrAddr] <= iWrData;
        if (iRe) oRdData <= mem[iRdAddr];
    end

endmodule

// File: rtl/pgb_frame_capture.sv
// Framebuffer sink: captures GPU word writes into ping-pong banks and streams
// each committed frame out as MSB-first pixels over valid/ready.
module pgb_frame_capture
    import pgb_frame_capture_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int LAST_ADDR  = DEF_LAST_ADDR,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iCaptureEnable,
    input  logic              iFbWe,
    input  logic [15:0]       iFbAddr,
    input  logic [DATA_W-1:0] iFbData,
    output logic              oPixValid,
    input  logic              iPixReady,
    output logic [PIX_W-1:0]  oPixData,
    output logic              oPixFirst,
    output logic              oPixLast,
    output logic              oLineEnd,
    output logic              oBusy,
    output logic [15:0]       oFrameCount,
    output logic              oOverrun
);

    localparam int PPW       = pixPerWord(DATA_W, PIX_W);
    localparam int PIX_IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [ADDR_W-1:0]    LAST_WORD = ADDR_W'(LAST_ADDR);
    localparam logic [PIX_IDX_W-1:0] LAST_PIX  = PIX_IDX_W'(PPW - 1);

    streamState_t           state;
    logic                   capBank;
    logic                   streamBank;
    logic [ADDR_W-1:0]      wordPtr;
    logic [PIX_IDX_W-1:0]   pixIdx;
    logic [DATA_W-1:0]      shiftReg;
    logic [1:0][DATA_W-1:0] bankRd;
    logic [DATA_W-1:0]      rdWord;

    logic fbHit, wrEn, commit, pixXfer, lastXfer, startOk;
    logic isLastWord, isLineWord;

    assign fbHit      = iFbWe & iCaptureEnable & (iFbAddr <= 16'(LAST_ADDR));
    // A single bank cannot be rewritten while it is being streamed.
    assign wrEn       = fbHit & ((NUM_BANKS > 1) | ~oBusy);
    assign commit     = fbHit & (iFbAddr == 16'(LAST_ADDR));
    assign pixXfer    = oPixValid & iPixReady;
    assign isLastWord = (wordPtr == LAST_WORD);
    assign isLineWord = (((int'(wordPtr) + 1) % LINE_WORDS) == 0);
    assign lastXfer   = pixXfer & (state == ST_SHIFT) & (pixIdx == LAST_PIX) & isLastWord;
    assign startOk    = ~oBusy | (lastXfer & (NUM_BANKS > 1));
    assign rdWord     = bankRd[streamBank];
    assign oPixData   = shiftReg[DATA_W-1 -: PIX_W];

    for (genvar b = 0; b < 2; b++) begin : gBank
        if (b < NUM_BANKS) begin : gRam
            pgb_fb_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uRam (
                .iClock  (iClock),
                .iWe     (wrEn & (capBank == 1'(b))),
                .iWrAddr (iFbAddr[ADDR_W-1:0]),
                .iWrData (iFbData),
                .iRe     (state == ST_FETCH),
                .iRdAddr (wordPtr),
                .oRdData (bankRd[b])
            );
        end else begin : gNone
            assign bankRd[b] = '0;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state       <= ST_IDLE;
            capBank     <= 1'b0;
            streamBank  <= 1'b0;
            wordPtr     <= '0;
            pixIdx      <= '0;
            shiftReg    <= '0;
            oPixValid   <= 1'b0;
            oPixFirst   <= 1'b0;
            oPixLast    <= 1'b0;
            oLineEnd    <= 1'b0;
            oBusy       <= 1'b0;
            oFrameCount <= '0;
            oOverrun    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:  ;
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    shiftReg  <= rdWord;
                    pixIdx    <= '0;
                    oPixValid <= 1'b1;
                    oPixFirst <= (wordPtr == '0);
                    oPixLast  <= (PPW == 1) && isLastWord;
                    oLineEnd  <= (PPW == 1) && isLineWord;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: if (pixXfer) begin
                    if (pixIdx == LAST_PIX) begin
                        oPixValid <= 1'b0;
                        oPixFirst <= 1'b0;
                        oPixLast  <= 1'b0;
                        oLineEnd  <= 1'b0;
                        wordPtr   <= wordPtr + 1'b1;
                        if (isLastWord) begin
                            state <= ST_IDLE;
                            oBusy <= 1'b0;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        // Qualifiers are precomputed for the pixel about to be presented.
                        shiftReg  <= shiftReg << PIX_W;
                        pixIdx    <= pixIdx + 1'b1;
                        oPixFirst <= 1'b0;
                        oPixLast  <= ((pixIdx + 1'b1) == LAST_PIX) && isLastWord;
                        oLineEnd  <= ((pixIdx + 1'b1) == LAST_PIX) && isLineWord;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Commit overrides the FSM so a stream can restart on its own final handshake.
            if (commit) begin
                if (startOk) begin
                    state       <= ST_FETCH;
                    oBusy       <= 1'b1;
                    wordPtr     <= '0;
                    streamBank  <= capBank;
                    if (NUM_BANKS > 1) capBank <= ~capBank;
                    oFrameCount <= oFrameCount + 16'd1;
                end else begin
                    oOverrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pgb_frame_capture.sv
// Directed bench for pgb_frame_capture on a reduced 28-word frame.
module tb_pgb_frame_capture;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 16;
    localparam int PIX_W      = 2;
    localparam int LAST_ADDR  = 27;
    localparam int LINE_WORDS = 4;
    localparam int NUM_BANKS  = 2;
    localparam int PPW        = 8;
    localparam int NPIX       = (LAST_ADDR + 1) * PPW;

    logic              iClock, iReset, iCaptureEnable, iFbWe, iPixReady;
    logic [15:0]       iFbAddr;
    logic [DATA_W-1:0] iFbData;
    logic              oPixValid, oPixFirst, oPixLast, oLineEnd, oBusy, oOverrun;
    logic [PIX_W-1:0]  oPixData;
    logic [15:0]       oFrameCount;

    int nTests = 0;
    int nFail  = 0;
    int expCount = 0;

    logic [1:0] cPix [NPIX];
    logic       cFirst [NPIX];
    logic       cLast [NPIX];
    logic       cLe [NPIX];
    int nPix, stallViol;
    bit timedOut;

    pgb_frame_capture #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W), .LAST_ADDR(LAST_ADDR),
        .LINE_WORDS(LINE_WORDS), .NUM_BANKS(NUM_BANKS)
    ) dut (
        .iClock(iClock), .iReset(iReset), .iCaptureEnable(iCaptureEnable), .iFbWe(iFbWe),
        .iFbAddr(iFbAddr), .iFbData(iFbData), .oPixValid(oPixValid), .iPixReady(iPixReady),
        .oPixData(oPixData), .oPixFirst(oPixFirst), .oPixLast(oPixLast), .oLineEnd(oLineEnd),
        .oBusy(oBusy), .oFrameCount(oFrameCount), .oOverrun(oOverrun)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    function automatic logic [15:0] patt(input int mode, input int k);
        case (mode)
            0:       return 16'(k);
            1:       return 16'hFFFF;
            2:       return 16'hAAAA;
            default: return 16'(k * 40503 + 4660);
        endcase
    endfunction

    function automatic logic [1:0] expPix(input int mode, input int p);
        logic [15:0] w;
        w = patt(mode, p / PPW);
        return 2'((w >> (14 - 2 * (p % PPW))) & 16'h3);
    endfunction

    function automatic int dataErr(input int mode);
        int e = 0;
        for (int p = 0; p < NPIX; p++) if (cPix[p] !== expPix(mode, p)) e++;
        return e;
    endfunction

    task automatic fbWrite(input logic [15:0] a, input logic [15:0] d, input logic en);
        iFbAddr = a; iFbData = d; iCaptureEnable = en; iFbWe = 1'b1;
        @(posedge iClock); #1;
        iFbWe = 1'b0; iCaptureEnable = 1'b1;
    endtask

    task automatic writeFrame(input int mode, input int lastW);
        for (int k = 0; k <= lastW; k++) fbWrite(16'(k), patt(mode, k), 1'b1);
    endtask

    // Drains up to maxPix pixels; records stalled cycles whose outputs moved.
    task automatic collect(input int readyPct, input int maxPix);
        logic pv; logic [1:0] pd; logic pf, pl, pe;
        bit havePrev = 0;
        nPix = 0; stallViol = 0; timedOut = 0;
        pv = 0; pd = 0; pf = 0; pl = 0; pe = 0;
        for (int cyc = 0; cyc < 4000 && nPix < maxPix; cyc++) begin
            iPixReady = (int'($urandom_range(99)) < readyPct);
            @(negedge iClock);
            if (havePrev && ({oPixValid, oPixData, oPixFirst, oPixLast, oLineEnd} !== {pv, pd, pf, pl, pe}))
                stallViol++;
            havePrev = oPixValid && !iPixReady;
            {pv, pd, pf, pl, pe} = {oPixValid, oPixData, oPixFirst, oPixLast, oLineEnd};
            if (oPixValid && iPixReady) begin
                cPix[nPix] = oPixData; cFirst[nPix] = oPixFirst;
                cLast[nPix] = oPixLast; cLe[nPix] = oLineEnd;
                nPix++;
            end
            @(posedge iClock); #1;
        end
        iPixReady = 1'b0;
        if (nPix < maxPix) timedOut = 1;
    endtask

    task automatic test_reset();
        iReset = 1'b0; iCaptureEnable = 1'b1; iFbWe = 1'b0; iFbAddr = '0; iFbData = '0; iPixReady = 1'b0;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        nTests++;
        if ({oPixValid, oPixData, oPixFirst, oPixLast, oLineEnd, oBusy, oOverrun} !== 8'h00) begin
            nFail++; $display("FAIL reset_outputs: got %b want 00000000",
                {oPixValid, oPixData, oPixFirst, oPixLast, oLineEnd, oBusy, oOverrun});
        end
        nTests++;
        if (oFrameCount !== 16'd0) begin nFail++; $display("FAIL reset_count: got %0d want 0", oFrameCount); end
        iReset = 1'b1;
        @(posedge iClock); #1;
    endtask

    task automatic test_full_frame();
        logic [15:0] w3;
        int nf, nl;
        writeFrame(0, LAST_ADDR); expCount++;
        collect(100, NPIX);
        nTests++;
        if (timedOut) begin nFail++; $display("FAIL t1_pixels: got %0d want %0d", nPix, NPIX); end
        nTests++;
        if (dataErr(0) !== 0) begin nFail++; $display("FAIL t1_data: got %0d bad pixels want 0", dataErr(0)); end
        w3 = '0;
        for (int i = 0; i < PPW; i++) w3 = {w3[13:0], cPix[3 * PPW + i]};
        nTests++;
        if (w3 !== 16'h0003) begin nFail++; $display("FAIL t1_word3: got %h want 0003", w3); end
        nf = 0; nl = 0;
        for (int p = 0; p < NPIX; p++) begin nf += int'(cFirst[p]); nl += int'(cLast[p]); end
        nTests++;
        if (nf !== 1 || cFirst[0] !== 1'b1) begin nFail++; $display("FAIL t1_first: got count %0d at0 %b want 1 1", nf, cFirst[0]); end
        nTests++;
        if (nl !== 1 || cLast[NPIX-1] !== 1'b1) begin nFail++; $display("FAIL t1_last: got count %0d atEnd %b want 1 1", nl, cLast[NPIX-1]); end
        nTests++;
        if (oFrameCount !== 16'(expCount)) begin nFail++; $display("FAIL t1_count: got %0d want %0d", oFrameCount, expCount); end
        nTests++;
        if (oBusy !== 1'b0 || oOverrun !== 1'b0) begin nFail++; $display("FAIL t1_idle: got busy %b ovr %b want 0 0", oBusy, oOverrun); end
    endtask

    task automatic test_random_ready();
        writeFrame(0, LAST_ADDR); expCount++;
        collect(50, NPIX);
        nTests++;
        if (timedOut) begin nFail++; $display("FAIL t2_pixels: got %0d want %0d", nPix, NPIX); end
        nTests++;
        if (dataErr(0) !== 0) begin nFail++; $display("FAIL t2_data: got %0d bad pixels want 0", dataErr(0)); end
        nTests++;
        if (stallViol !== 0) begin nFail++; $display("FAIL t2_stall_stable: got %0d unstable cycles want 0", stallViol); end
        nTests++;
        if (cFirst[0] !== 1'b1 || cLast[NPIX-1] !== 1'b1) begin nFail++; $display("FAIL t2_flags: got %b%b want 11", cFirst[0], cLast[NPIX-1]); end
    endtask

    task automatic test_line_end();
        int nle, bad;
        writeFrame(3, LAST_ADDR); expCount++;
        collect(100, NPIX);
        nle = 0; bad = 0;
        for (int p = 0; p < NPIX; p++) begin
            nle += int'(cLe[p]);
            if (cLe[p] !== ((p % 32) == 31)) bad++;
        end
        nTests++;
        if (nle !== 7) begin nFail++; $display("FAIL t4_line_count: got %0d want 7", nle); end
        nTests++;
        if (bad !== 0) begin nFail++; $display("FAIL t4_line_pos: got %0d misplaced want 0", bad); end
        nTests++;
        if (dataErr(3) !== 0) begin nFail++; $display("FAIL t4_data: got %0d bad pixels want 0", dataErr(3)); end
    endtask

    task automatic test_ignored_writes();
        writeFrame(3, LAST_ADDR - 1);
        for (int k = 0; k < LAST_ADDR; k++) begin
            fbWrite(16'(16'h0020 + k), 16'h5555, 1'b1);
            fbWrite(16'(k), 16'h5555, 1'b0);
            fbWrite(16'(16'hFFE0 + k), 16'h5555, 1'b1);
        end
        fbWrite(16'(LAST_ADDR), 16'h5555, 1'b0);
        fbWrite(16'(16'h0020 + LAST_ADDR), 16'h5555, 1'b1);
        fbWrite(16'(LAST_ADDR + 1), 16'h5555, 1'b1);
        fbWrite(16'hFFFF, 16'h5555, 1'b1);
        repeat (3) @(posedge iClock); #1;
        nTests++;
        if (oFrameCount !== 16'(expCount) || oBusy !== 1'b0) begin
            nFail++; $display("FAIL t5_no_commit: got count %0d busy %b want %0d 0", oFrameCount, oBusy, expCount);
        end
        fbWrite(16'(LAST_ADDR), patt(3, LAST_ADDR), 1'b1); expCount++;
        collect(100, NPIX);
        nTests++;
        if (timedOut || dataErr(3) !== 0) begin
            nFail++; $display("FAIL t5_ram_intact: got %0d bad of %0d want 0 of %0d", dataErr(3), nPix, NPIX);
        end
    endtask

    task automatic test_overrun();
        nTests++;
        if (oOverrun !== 1'b0) begin nFail++; $display("FAIL t3_pre_overrun: got %b want 0", oOverrun); end
        writeFrame(1, LAST_ADDR); expCount++;
        writeFrame(2, LAST_ADDR);
        nTests++;
        if (oOverrun !== 1'b1 || oBusy !== 1'b1) begin nFail++; $display("FAIL t3_overrun: got ovr %b busy %b want 1 1", oOverrun, oBusy); end
        nTests++;
        if (oFrameCount !== 16'(expCount)) begin nFail++; $display("FAIL t3_count: got %0d want %0d", oFrameCount, expCount); end
        collect(100, NPIX);
        nTests++;
        if (timedOut || dataErr(1) !== 0) begin nFail++; $display("FAIL t3_frameA: got %0d bad of %0d want 0", dataErr(1), nPix); end
        fbWrite(16'(LAST_ADDR), 16'hAAAA, 1'b1); expCount++;
        collect(100, NPIX);
        nTests++;
        if (timedOut || dataErr(2) !== 0) begin nFail++; $display("FAIL t3_frameB: got %0d bad of %0d want 0", dataErr(2), nPix); end
        nTests++;
        if (oFrameCount !== 16'(expCount) || oOverrun !== 1'b1) begin
            nFail++; $display("FAIL t3_sticky: got count %0d ovr %b want %0d 1", oFrameCount, oOverrun, expCount);
        end
    endtask

    task automatic test_reset_midstream();
        writeFrame(0, LAST_ADDR);
        collect(100, 100);
        #2 iReset = 1'b0;
        #1;
        nTests++;
        if ({oPixValid, oPixData, oPixFirst, oPixLast, oLineEnd, oBusy, oOverrun} !== 8'h00 || oFrameCount !== 16'd0) begin
            nFail++; $display("FAIL t6_abort: got %b count %0d want 00000000 0",
                {oPixValid, oPixData, oPixFirst, oPixLast, oLineEnd, oBusy, oOverrun}, oFrameCount);
        end
        @(negedge iClock); iReset = 1'b1;
        @(posedge iClock); #1;
        expCount = 0;
        writeFrame(3, LAST_ADDR); expCount++;
        collect(100, NPIX);
        nTests++;
        if (timedOut || dataErr(3) !== 0) begin nFail++; $display("FAIL t6_restart_data: got %0d bad of %0d want 0", dataErr(3), nPix); end
        nTests++;
        if (cFirst[0] !== 1'b1 || oFrameCount !== 16'(expCount)) begin
            nFail++; $display("FAIL t6_restart_first: got first %b count %0d want 1 %0d", cFirst[0], oFrameCount, expCount);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_ready();
        test_line_end();
        test_ignored_writes();
        test_overrun();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
